mcdf_formatter: RTL and testbench



---
 rtl/mcdf_formatter.sv | 149 ++++++++++++++
 tb/tb_mcdf_formatter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcdf_formatter.sv
// Single-packet formatter: buffers len words from one arbiter channel, requests the bus, then streams them with framing.
// Backpressure: fmt_ready drops while another channel is selected and during REQ/SEND; optional FMT_PARITY_EN adds fmt_parity.
module mcdf_formatter #(
  parameter int FIFO_WIDE = 32,
  parameter int BUF_DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           arb_ch_chosen,
  input  logic [FIFO_WIDE-1:0] arb_data_in,
  input  logic                 arb_valid,
  output logic                 fmt_ready,
  input  logic [1:0]           fmt_ch0_len,
  input  logic [1:0]           fmt_ch1_len,
  input  logic [1:0]           fmt_ch2_len,
  input  logic                 fmt_grant,
  output logic                 fmt_req,
  output logic                 fmt_send,
  output logic                 fmt_start,
  output logic                 fmt_end,
  output logic [FIFO_WIDE-1:0] fmt_data,
  output logic [1:0]           fmt_chid,
  output logic [5:0]           fmt_length
`ifdef FMT_PARITY_EN
  ,
  output logic                 fmt_parity
`endif
);

  localparam int AW = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, COLLECT, REQ, SEND} state_t;

  state_t               state;
  logic [1:0]           chid_q;
  logic [5:0]           len_q;
  logic [5:0]           cnt;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_idx;
  logic [FIFO_WIDE-1:0] buf_mem [BUF_DEPTH];
  logic [1:0]           sel_code;
  logic [5:0]           sel_len;
  logic                 xfer;

  always_comb begin
    sel_code = fmt_ch2_len;
    case (arb_ch_chosen)
      2'd0:    sel_code = fmt_ch0_len;
      2'd1:    sel_code = fmt_ch1_len;
      default: sel_code = fmt_ch2_len;
    endcase
    sel_len = 6'd4 << sel_code;
  end

  // chid_q never holds 2'b11, so the "none" selection is rejected while collecting.
  assign fmt_ready = rst_n && ((state == IDLE) ||
                               (state == COLLECT && arb_ch_chosen == chid_q));
  assign xfer      = fmt_ready && arb_valid && (arb_ch_chosen != 2'b11);
  assign wr_idx    = (state == IDLE) ? '0 : wr_ptr;

  always_ff @(posedge clk) begin
    if (xfer) buf_mem[wr_idx] <= arb_data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      chid_q     <= '0;
      len_q      <= '0;
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fmt_req    <= 1'b0;
      fmt_send   <= 1'b0;
      fmt_start  <= 1'b0;
      fmt_end    <= 1'b0;
      fmt_data   <= '0;
      fmt_chid   <= '0;
      fmt_length <= '0;
`ifdef FMT_PARITY_EN
      fmt_parity <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            chid_q     <= arb_ch_chosen;
            len_q      <= sel_len;
            fmt_chid   <= arb_ch_chosen;
            fmt_length <= sel_len;
            cnt        <= 6'd1;
            wr_ptr     <= AW'(1);
            state      <= COLLECT;
          end
        end
        COLLECT: begin
          if (xfer) begin
            cnt    <= cnt + 6'd1;
            wr_ptr <= wr_ptr + AW'(1);
            if (cnt + 6'd1 == len_q) begin
              state   <= REQ;
              fmt_req <= 1'b1;
            end
          end
        end
        REQ: begin
          // Word 0 is loaded on the grant edge so the first send cycle carries data.
          if (fmt_grant) begin
            state     <= SEND;
            fmt_req   <= 1'b0;
            fmt_send  <= 1'b1;
            fmt_start <= 1'b1;
            fmt_end   <= (len_q == 6'd1);
            fmt_data  <= buf_mem[AW'(0)];
            cnt       <= '0;
            rd_ptr    <= '0;
`ifdef FMT_PARITY_EN
            fmt_parity <= ^buf_mem[AW'(0)];
`endif
          end
        end
        SEND: begin
          if (cnt == len_q - 6'd1) begin
            state     <= IDLE;
            fmt_send  <= 1'b0;
            fmt_start <= 1'b0;
            fmt_end   <= 1'b0;
            fmt_data  <= '0;
`ifdef FMT_PARITY_EN
            fmt_parity <= 1'b0;
`endif
          end else begin
            cnt       <= cnt + 6'd1;
            rd_ptr    <= rd_ptr + AW'(1);
            fmt_start <= 1'b0;
            fmt_end   <= (cnt + 6'd1 == len_q - 6'd1);
            fmt_data  <= buf_mem[rd_ptr + AW'(1)];
`ifdef FMT_PARITY_EN
            fmt_parity <= ^buf_mem[rd_ptr + AW'(1)];
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcdf_formatter.sv
// Scoreboard bench for mcdf_formatter: driver pushes expected packets, negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_mcdf_formatter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  arb_ch_chosen = 2'b11;
  logic [31:0] arb_data_in = '0;
  logic        arb_valid = 1'b0;
  logic        fmt_ready;
  logic [1:0]  fmt_ch0_len = '0, fmt_ch1_len = '0, fmt_ch2_len = '0;
  logic        fmt_grant = 1'b0;
  logic        fmt_req, fmt_send, fmt_start, fmt_end;
  logic [31:0] fmt_data;
  logic [1:0]  fmt_chid;
  logic [5:0]  fmt_length;
`ifdef FMT_PARITY_EN
  logic        fmt_parity;
`endif

  mcdf_formatter #(.FIFO_WIDE(32), .BUF_DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .arb_ch_chosen(arb_ch_chosen), .arb_data_in(arb_data_in), .arb_valid(arb_valid),
    .fmt_ready(fmt_ready),
    .fmt_ch0_len(fmt_ch0_len), .fmt_ch1_len(fmt_ch1_len), .fmt_ch2_len(fmt_ch2_len),
    .fmt_grant(fmt_grant), .fmt_req(fmt_req), .fmt_send(fmt_send),
    .fmt_start(fmt_start), .fmt_end(fmt_end), .fmt_data(fmt_data),
    .fmt_chid(fmt_chid), .fmt_length(fmt_length)
`ifdef FMT_PARITY_EN
    , .fmt_parity(fmt_parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w [32];
    int          len;
    logic [1:0]  ch;
  } pkt_t;

  pkt_t        exp_q [$];
  pkt_t        cur;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          in_pkt = 0;
  int          k = 0;
  bit          req_due = 0, prev_req = 0, prev_grant = 0, was_end = 0;
  int          gdelay = -1;
  int          req_cnt = 0;
  logic [31:0] words [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Grant source: fixed delay after request rises, or random toggling (gdelay < 0).
  initial begin
    forever begin
      @(posedge clk); #1;
      if (fmt_req) req_cnt++; else req_cnt = 0;
      if (gdelay < 0) fmt_grant = ($urandom_range(0, 2) == 0);
      else            fmt_grant = (req_cnt > gdelay);
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      in_pkt = 0; exp_q.delete(); req_due = 0; prev_req = 0; prev_grant = 0; was_end = 0;
    end else begin
      if (req_due) begin chk("req_rise", 32'(fmt_req), 32'd1); req_due = 0; end
      if (prev_req) begin
        if (prev_grant) begin
          chk("grant_send", 32'({fmt_req, fmt_send, fmt_start}), 32'b011);
        end else begin
          chk("req_hold", 32'({fmt_req, fmt_send}), 32'b10);
        end
      end
      if (was_end) begin chk("ready_return", 32'({fmt_ready, fmt_send}), 32'b10); was_end = 0; end
      if (fmt_req || fmt_send) chk("ready_busy", 32'(fmt_ready), 32'd0);
      if (fmt_send && !in_pkt) begin
        if (exp_q.size() == 0) chk("unexpected_send", 32'(fmt_send), 32'd0);
        else begin cur = exp_q.pop_front(); in_pkt = 1; k = 0; end
      end
      if (in_pkt) begin
        if (!fmt_send) begin
          chk("send_gap", 32'(fmt_send), 32'd1);
          in_pkt = 0;
        end else begin
          chk("data",   fmt_data, cur.w[k]);
          chk("start",  32'(fmt_start), 32'(k == 0));
          chk("end",    32'(fmt_end), 32'(k == cur.len - 1));
          chk("chid",   32'(fmt_chid), 32'(cur.ch));
          chk("length", 32'(fmt_length), cur.len);
`ifdef FMT_PARITY_EN
          chk("parity", 32'(fmt_parity), 32'(^cur.w[k]));
`endif
          k++;
          if (k == cur.len) begin in_pkt = 0; was_end = 1; end
        end
      end
`ifdef FMT_PARITY_EN
      else chk("parity_idle", 32'(fmt_parity), 32'd0);
`endif
      prev_req = fmt_req;
      prev_grant = fmt_grant;
    end
  end

  task automatic set_code(input logic [1:0] ch, input logic [1:0] code);
    case (ch)
      2'd0:    fmt_ch0_len = code;
      2'd1:    fmt_ch1_len = code;
      default: fmt_ch2_len = code;
    endcase
  endtask

  // Entered and left at posedge+1.
  task automatic drive_pkt(input logic [1:0] ch, input logic [1:0] code, input int gd,
                           input int intr_at, input bit bubbles, input bit fixed, input bit wait_done);
    pkt_t p;
    int   len, typ, oc;
    bit   ok;
    gdelay = gd;
    len = 4 << code;
    p.ch = ch;
    p.len = len;
    for (int i = 0; i < 32; i++) begin
      p.w[i] = fixed ? words[i] : $urandom;
      words[i] = p.w[i];
    end
    exp_q.push_back(p);
    set_code(ch, code);
    oc = (int'(ch) + 2) % 3;
    for (int i = 0; i < len; i++) begin
      if (i == intr_at) begin
        for (int b = 0; b < 5; b++) begin
          arb_valid = 1'b1; arb_ch_chosen = 2'(oc); arb_data_in = $urandom;
          @(negedge clk); chk("intr_ready", 32'(fmt_ready), 32'd0);
          @(posedge clk); #1;
        end
      end
      if (bubbles && $urandom_range(0, 2) == 0) begin
        typ = $urandom_range(0, 2);
        if (i == 0 && typ == 2) typ = 1;
        arb_valid = (typ != 0);
        arb_ch_chosen = (typ == 1) ? 2'b11 : 2'(oc);
        arb_data_in = $urandom;
        @(negedge clk);
        if (typ != 0) chk("bubble_ready", 32'(fmt_ready), 32'(i == 0));
        @(posedge clk); #1;
      end
      arb_valid = 1'b1; arb_ch_chosen = ch; arb_data_in = p.w[i];
      @(negedge clk); chk("accept_ready", 32'(fmt_ready), 32'd1);
      @(posedge clk); #1;
      if (i == len - 1) req_due = 1;
      fmt_ch0_len = 2'($urandom_range(0, 3));
      fmt_ch1_len = 2'($urandom_range(0, 3));
      fmt_ch2_len = 2'($urandom_range(0, 3));
    end
    arb_valid = 1'b0; arb_ch_chosen = 2'b11;
    if (wait_done) begin
      ok = 0;
      for (int c = 0; c < 400; c++) begin
        @(posedge clk); #1;
        if (exp_q.size() == 0 && !in_pkt) begin ok = 1; break; end
      end
      chk("pkt_done", 32'(ok), 32'd1);
    end
  endtask

  initial begin
    bit found;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out", 32'({fmt_req, fmt_send, fmt_start, fmt_end, fmt_ready}), 32'd0);
    chk("rst_data", fmt_data, 32'd0);
    chk("rst_side", 32'({fmt_chid, fmt_length}), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(fmt_ready), 32'd1);
    chk("idle_out", 32'({fmt_req, fmt_send}), 32'd0);
    @(posedge clk); #1;

    // ch0, 4 words A0..A3, grant two cycles after request
    for (int i = 0; i < 32; i++) words[i] = 32'hA0 + i;
    drive_pkt(2'd0, 2'd0, 2, -1, 0, 1, 1);
    // ch2, 32 words, grant held high
    drive_pkt(2'd2, 2'd3, 0, -1, 0, 0, 1);
    // ch1, 8 words, arbiter flips to ch0 for 5 cycles after 3 words
    drive_pkt(2'd1, 2'd1, -1, 3, 0, 0, 1);
    // grant withheld 50 cycles
    drive_pkt(2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 50, -1, 1, 0, 1);
`ifdef FMT_PARITY_EN
    words[0] = 32'h1; words[1] = 32'h3; words[2] = 32'h7; words[3] = 32'h0;
    drive_pkt(2'd0, 2'd0, 0, -1, 0, 1, 1);
`endif
    for (int n = 0; n < 15; n++)
      drive_pkt(2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 4)), -1, 1, 0, 1);

    // reset during SEND word 2
    drive_pkt(2'd1, 2'd1, 0, -1, 0, 0, 0);
    found = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (fmt_send && fmt_data === words[2]) begin found = 1; break; end
    end
    chk("rst_reach_word2", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out", 32'({fmt_req, fmt_send, fmt_start, fmt_end, fmt_ready}), 32'd0);
    chk("midrst_data", fmt_data, 32'd0);
    chk("midrst_side", 32'({fmt_chid, fmt_length}), 32'd0);
`ifdef FMT_PARITY_EN
    chk("midrst_parity", 32'(fmt_parity), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("post_rst_ready", 32'(fmt_ready), 32'd1);
      chk("post_rst_send", 32'({fmt_send, fmt_req}), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
